mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'd1024, byte address of data-memory word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit memory words.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2 (range 0..15), extra memory wait states per access.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  pipeline memory request present.
REQ-007 SHALL have port req_wr  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_ready  output  1  controller idle and accepting.
REQ-011 SHALL have port freeze  output  1  stall upstream pipeline.
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata  output  32  load data.
REQ-014 SHALL have port resp_fault  output  1  request rejected.
REQ-015 SHALL have port MEM_r_en  output  1  memory read enable.
REQ-016 SHALL have port MEM_w_en  output  1  memory write enable.
REQ-017 SHALL have port mem_address  output  32  byte address to memory.
REQ-018 SHALL have port mem_wdata  output  32  write data to memory.
REQ-019 SHALL have port mem_rdata  input  32  combinational read data from memory.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, RESP; 4-bit wait counter.
REQ-021 IDLE: req_ready=1; on req_valid latch req_wr, req_addr, req_wdata at the clock edge.
REQ-022 Fault check at acceptance: fault if req_addr < BASE_ADDR, or req_addr >= BASE_ADDR+4*DEPTH_WORDS (32-bit unsigned compare, no wrap), or req_addr[1:0] != 0.
REQ-023 Fault request: IDLE -> RESP directly; MEM_r_en/MEM_w_en never asserted.
REQ-024 Valid request: IDLE -> ACCESS, counter loaded with WAIT_CYCLES.
REQ-025 ACCESS: mem_address = latched address, mem_wdata = latched data, both stable for the whole state; counter decrements each cycle; exit to RESP on the cycle counter==0 (ACCESS lasts WAIT_CYCLES+1 cycles).
REQ-026 Load: MEM_r_en=1 for every ACCESS cycle; mem_rdata captured into resp_rdata at the final ACCESS edge.
REQ-027 Store: MEM_w_en=1 only in the final ACCESS cycle (exactly one write edge); MEM_r_en=0.
REQ-028 RESP: resp_valid=1 for exactly one cycle, resp_fault valid alongside; resp_rdata=0 for stores and faults; always -> IDLE next cycle.
REQ-029 req_ready=0 in ACCESS and RESP; req_valid ignored there (no queueing).
REQ-030 freeze = (IDLE and req_valid) or ACCESS; combinational; freeze=0 in RESP.
REQ-031 Latency: accepted at edge T -> resp_valid in cycle T+2+WAIT_CYCLES (valid), T+1 (fault).
REQ-032 mem_address, mem_wdata SHALL be 0 outside ACCESS; MEM_r_en/MEM_w_en registered, glitch-free.
REQ-033 resp_rdata, resp_fault SHALL hold their values until the next RESP.

Reset
REQ-034 rst=0 SHALL immediately force state IDLE, counter 0, MEM_r_en=0, MEM_w_en=0, mem_address=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_fault=0, independent of clk.
REQ-035 Reset during ACCESS SHALL abort the access with no write edge after reset assertion; first request after release proceeds normally.

Verification
REQ-036 Load 0x404, WAIT_CYCLES=2, memory word1=0xDEADBEEF -> MEM_r_en high 3 cycles, resp_valid at T+4, resp_rdata=0xDEADBEEF, fault=0.
REQ-037 Store 0x4FC data 0x12345678 -> MEM_w_en high exactly 1 cycle with mem_address=0x4FC; subsequent load 0x4FC returns 0x12345678.
REQ-038 Requests 0x3FC, 0x500, 0x402 -> each resp_fault=1 at T+1, MEM enables never high, resp_rdata=0.
REQ-039 req_valid held high continuously -> requests serviced one at a time, req_ready=0 during ACCESS/RESP, freeze drops only in RESP.
REQ-040 rst pulsed low mid-ACCESS of store -> MEM_w_en falls immediately, memory unchanged, resp_valid never pulses for that request.
REQ-041 WAIT_CYCLES=0 load -> single ACCESS cycle, resp_valid at T+2.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding data-memory access controller with range/alignment
// fault checking, configurable wait states and pipeline freeze.
module mem_access_ctrl #(
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          DEPTH_WORDS = 64,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        freeze,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        MEM_r_en,
   output logic        MEM_w_en,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   localparam logic [1:0]  IDLE      = 2'd0;
   localparam logic [1:0]  ACCESS    = 2'd1;
   localparam logic [1:0]  RESP      = 2'd2;
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
   // 33-bit limit so a window ending at 4 GiB cannot wrap the compare
   localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic        fault_q, fault_d, r_en_q, r_en_d, w_en_q, w_en_d;
   logic        fault;

   assign fault = (req_addr < BASE_ADDR) || ({1'b0, req_addr} >= LIMIT) || (req_addr[1:0] != 2'b00);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      case (state_q)
         IDLE: if (req_valid) begin
            wr_d    = req_wr;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            state_d = fault ? RESP : ACCESS;
            cnt_d   = fault ? 4'd0 : WAIT_INIT;
            if (fault) begin
               fault_d = 1'b1;
               rdata_d = '0;
            end
         end
         ACCESS: if (cnt_q == 4'd0) begin
            state_d = RESP;
            fault_d = 1'b0;
            rdata_d = wr_q ? '0 : mem_rdata;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
      r_en_d = (state_d == ACCESS) && !wr_d;
      w_en_d = (state_d == ACCESS) && wr_d && (cnt_d == 4'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
         r_en_q  <= 1'b0;
         w_en_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
         r_en_q  <= r_en_d;
         w_en_q  <= w_en_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign freeze      = ((state_q == IDLE) && req_valid) || (state_q == ACCESS);
   assign resp_valid  = (state_q == RESP);
   assign resp_rdata  = rdata_q;
   assign resp_fault  = fault_q;
   assign MEM_r_en    = r_en_q;
   assign MEM_w_en    = w_en_q;
   assign mem_address = (state_q == ACCESS) ? addr_q : '0;
   assign mem_wdata   = (state_q == ACCESS) ? wdata_q : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl with a behavioural data memory;
// a second instance with WAIT_CYCLES=0 covers the zero-wait path.
module tb_mem_access_ctrl;
   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0, req_wr = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, freeze, resp_valid, resp_fault, MEM_r_en, MEM_w_en;
   logic [31:0] resp_rdata, mem_address, mem_wdata, mem_rdata;

   logic        req_valid0 = 1'b0;
   logic        req_ready0, freeze0, resp_valid0, resp_fault0, MEM_r_en0, MEM_w_en0;
   logic [31:0] resp_rdata0, mem_address0, mem_wdata0, mem_rdata0;

   logic [31:0] mem [64];
   logic [31:0] midx;
   int cyc = 0, total = 0, pass = 0;

   typedef struct {logic wr; logic f; logic [31:0] rd; logic [31:0] a; int cyc;} exp_t;
   exp_t exp_q[$];

   mem_access_ctrl #(.WAIT_CYCLES(W)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .freeze(freeze), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_fault(resp_fault), .MEM_r_en(MEM_r_en), .MEM_w_en(MEM_w_en),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

   mem_access_ctrl #(.WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid0), .req_wr(1'b0), .req_addr(32'h404),
      .req_wdata(32'h0), .req_ready(req_ready0), .freeze(freeze0), .resp_valid(resp_valid0),
      .resp_rdata(resp_rdata0), .resp_fault(resp_fault0), .MEM_r_en(MEM_r_en0), .MEM_w_en(MEM_w_en0),
      .mem_address(mem_address0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign midx       = (mem_address - 32'h400) >> 2;
   assign mem_rdata  = mem[midx[5:0]];
   assign mem_rdata0 = mem_address0 ^ 32'h5A5A_0000;
   always @(posedge clk) if (MEM_w_en) mem[midx[5:0]] <= mem_wdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Waits for an idle controller, presents one request for one cycle, queues its expectation.
   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic f, input logic [31:0] rd, input logic push);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
      if (push) exp_q.push_back('{wr, f, rd, a, cyc + 1 + (f ? 0 : W + 1)});
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   int r_cnt = 0, w_cnt = 0;
   logic [31:0] w_addr = '0;
   exp_t e;
   always @(negedge clk) begin
      if (!rst) begin
         r_cnt = 0; w_cnt = 0;
      end else begin
         if (MEM_r_en) r_cnt++;
         if (MEM_w_en) begin w_cnt++; w_addr = mem_address; end
         if (resp_valid) begin
            if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("rdata", resp_rdata, e.rd);
               chk("fault", 32'(resp_fault), 32'(e.f));
               chk("latency", 32'(cyc), 32'(e.cyc));
               chk("r_en_cycles", 32'(r_cnt), (!e.wr && !e.f) ? 32'(W + 1) : 32'd0);
               chk("w_en_cycles", 32'(w_cnt), (e.wr && !e.f) ? 32'd1 : 32'd0);
               if (e.wr && !e.f) chk("w_addr", w_addr, e.a);
               chk("freeze_in_resp", 32'(freeze), 32'd0);
               chk("ready_in_resp", 32'(req_ready), 32'd0);
               r_cnt = 0; w_cnt = 0;
            end
         end
      end
   end

   initial begin
      int c0, n0, got;
      for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
      mem[1] = 32'hDEAD_BEEF;
      #2;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_enables", {30'd0, MEM_r_en, MEM_w_en}, 32'd0);
      chk("rst_mem_addr", mem_address, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      issue(1'b0, 32'h404, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
      issue(1'b1, 32'h4FC, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
      issue(1'b0, 32'h4FC, 32'h0, 1'b0, 32'h1234_5678, 1'b1);
      issue(1'b0, 32'h3FC, 32'h0, 1'b1, 32'h0, 1'b1);
      issue(1'b1, 32'h500, 32'h1111_2222, 1'b1, 32'h0, 1'b1);
      issue(1'b0, 32'h402, 32'h0, 1'b1, 32'h0, 1'b1);
      issue(1'b0, 32'h400, 32'h0, 1'b0, 32'hC0DE_0000, 1'b1);

      // req_valid held high: two back-to-back services of the same load
      @(negedge clk);
      while (!req_ready) @(negedge clk);
      c0 = cyc;
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h408;
      exp_q.push_back('{1'b0, 1'b0, 32'hC0DE_0002, 32'h408, c0 + 4});
      exp_q.push_back('{1'b0, 1'b0, 32'hC0DE_0002, 32'h408, c0 + 9});
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         chk("freeze_hold", 32'(freeze), 32'(!resp_valid));
         chk("ready_hold", 32'(req_ready), 32'(i == 5));
      end
      req_valid = 1'b0;

      // reset pulse during the write cycle of a store aborts it
      issue(1'b1, 32'h410, 32'hAAAA_5555, 1'b0, 32'h0, 1'b0);
      n0 = 0;
      while (!MEM_w_en && n0 < 10) begin @(negedge clk); n0++; end
      chk("store_w_en_seen", 32'(MEM_w_en), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rst_w_en_drop", 32'(MEM_w_en), 32'd0);
      chk("rst_addr_drop", mem_address, 32'd0);
      chk("rst_ready_async", 32'(req_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      chk("mem_unchanged", mem[4], 32'hC0DE_0004);
      issue(1'b0, 32'h410, 32'h0, 1'b0, 32'hC0DE_0004, 1'b1);

      // zero-wait instance: single ACCESS cycle
      @(negedge clk);
      c0 = cyc; n0 = 0; got = 0;
      req_valid0 = 1'b1;
      for (int i = 0; i < 6 && got == 0; i++) begin
         @(negedge clk);
         req_valid0 = 1'b0;
         if (MEM_r_en0) n0++;
         if (resp_valid0) begin
            got = 1;
            chk("w0_latency", 32'(cyc), 32'(c0 + 2));
            chk("w0_rdata", resp_rdata0, 32'h5A5A_0404);
            chk("w0_r_en_cycles", 32'(n0), 32'd1);
         end
      end
      if (got == 0) chk("w0_timeout", 32'd0, 32'd1);

      for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) chk("drain", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
